uart_mem_server: RTL
====================

# uart_mem_server

Memory responder for the byte-serial memory protocol: the far end of the UART link used by the main-memory client. Parses READ/WRITE command frames from a UART receiver byte stream and executes them on a local word-wide memory port. Returns ACK (with read data) or RESEND frames through a UART transmitter byte stream. Sits on the FPGA/simulator side, between a UART_rx/UART_tx pair and a RAM controller.

## Interface
- ADDR_W, 16: address width; sent as 2 bytes, MSB first.
- DATA_W, 32: data width; sent as 4 bytes, MSB first.
- TIMEOUT_CYC, 100000: maximum idle cycles between bytes inside a frame.

Ports:
- clk  in  1  clock; all logic on posedge.
- res_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle pulse; rx_data is valid.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data is valid; held until accepted.
- tx_ready  in  1  transmitter accepts the byte on tx_valid & tx_ready.
- mem_req  out  1  memory access request; held until mem_ack.
- mem_we  out  1  1 = write, 0 = read; stable while mem_req.
- mem_addr  out  ADDR_W  access address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data; valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle access completion.
- frame_err  out  1  one-cycle pulse on any rejected frame.

## Operation
- Command codes: ACK = 0x01, RESEND = 0x02, READ = 0x03, WRITE = 0x04.
- Request frames:
  - READ: cmd, addr[15:8], addr[7:0], chk (4 bytes).
  - WRITE: cmd, addr (2 bytes), data (4 bytes), chk (8 bytes).
- chk is the XOR of all preceding bytes in the frame.
- Response frames:
  - WRITE done: 0x01.
  - READ done: 0x01, d[31:24], d[23:16], d[15:8], d[7:0], chk (XOR of the preceding 5 bytes).
  - Rejected frame: 0x02.
- Rejection causes: unknown command byte; chk mismatch; inter-byte timeout. Each rejection pulses frame_err for 1 cycle and sends RESEND.
- FSM states:
  - IDLE → RECV on the first rx_valid. An unknown cmd byte goes straight to REJECT.
  - RECV collects bytes until the expected length for the command. Running XOR is compared with the last byte: match → MEM, mismatch → REJECT.
  - RECV timeout: counter reloads on every byte. Reaching TIMEOUT_CYC → REJECT.
  - MEM asserts mem_req until mem_ack, latching mem_rdata → SEND.
  - REJECT → SEND with a 1-byte RESEND frame.
  - SEND drives the response bytes one handshake each, then → IDLE.
- A memory write is never issued for a rejected frame.
- rx_valid during MEM/SEND/REJECT: byte dropped, frame_err pulses. The block is half-duplex by protocol.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State = IDLE; byte count, XOR and timeout counter cleared.
  - tx_valid = 0, tx_data = 0x00, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, frame_err = 0.
- Reset mid-frame or mid-access discards everything. No response is sent. A pending mem_ack after reset is ignored.
- Last request byte (rx_valid) → mem_req = 1 on the next cycle (1-cycle latency). A chk failure instead raises tx_valid on the next cycle.
- mem_ack cycle → tx_valid = 1 with tx_data = 0x01 on the next cycle.
- Handshake rule: tx_data changes only in the cycle after a tx_valid & tx_ready handshake. tx_valid never drops without a handshake.
- mem_ack arriving together with mem_req deassert logic: the request ends in that same cycle. mem_req must not be re-raised for the same frame.
- Simultaneous rx_valid and timeout expiry: the byte wins; the counter reloads.
- Address/data bytes are shifted in MSB-first. No byte-count wrap: the counter saturates at the frame length.

## Structure
- Shared package uart_mem_pkg:
  - MemCmd enum (8-bit, the codes above).
  - Frame-length constants READ_LEN = 4, WRITE_LEN = 8, RDRESP_LEN = 6.
  - The FSM state enum.
- Natural sub-module: uart_mem_txq, a response serializer. It loads up to 6 bytes plus a length in one cycle and drives the tx_valid/tx_ready handshake. The top holds the receive FSM and memory port.

## Test plan
- WRITE 04 00 10 DE AD BE EF 36 → one mem_req with mem_we = 1, addr 0x0010, wdata 0xDEADBEEF; response 01.
- Then READ 03 00 10 13, mem_rdata 0xDEADBEEF → mem_req with mem_we = 0, addr 0x0010; response 01 DE AD BE EF 23.
- WRITE with chk 0x37 → no mem_req; frame_err pulse; response 02.
- Cmd byte 0x07 → frame_err; response 02; the next valid READ is served normally.
- READ 03 00 stalled for TIMEOUT_CYC cycles → response 02. A late byte 10 starts a new frame and is then rejected as an unknown command.
- tx_ready held low 50 cycles mid-response → tx_data stable, no byte lost.
- res_n pulsed during MEM → all outputs at reset values; no response sent.

Source files
------------

// File: rtl/uart_mem_pkg.sv
// uart_mem_pkg: shared command codes, frame lengths and FSM states for the UART memory server.
package uart_mem_pkg;

    typedef enum logic [7:0] {
        CMD_ACK    = 8'h01,
        CMD_RESEND = 8'h02,
        CMD_READ   = 8'h03,
        CMD_WRITE  = 8'h04
    } mem_cmd_e;

    localparam int READ_LEN   = 4;
    localparam int WRITE_LEN  = 8;
    localparam int RDRESP_LEN = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_MEM,
        ST_REJECT,
        ST_SEND
    } state_e;

    function automatic logic [7:0] xor_word(input logic [31:0] w);
        return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction

endpackage

// File: rtl/uart_mem_txq.sv
// uart_mem_txq: response serializer; loads up to RDRESP_LEN bytes at once and
// shifts them out over the tx_valid/tx_ready handshake, byte 0 first.
module uart_mem_txq
    import uart_mem_pkg::*;
(
    input  logic                         clk,
    input  logic                         res_n,
    input  logic                         load_i,
    input  logic [RDRESP_LEN-1:0][7:0]   bytes_i,
    input  logic [2:0]                   len_i,
    output logic [7:0]                   tx_data_o,
    output logic                         tx_valid_o,
    input  logic                         tx_ready_i,
    output logic                         busy_o
);

    logic [RDRESP_LEN-1:0][7:0] sh_q, sh_d;
    logic [2:0]                 len_q, len_d;
    logic                       hs;

    // tx_data only moves after a completed handshake since byte 0 is the output
    assign hs         = (len_q != 3'd0) && tx_ready_i;
    assign tx_data_o  = sh_q[0];
    assign tx_valid_o = len_q != 3'd0;
    assign busy_o     = tx_valid_o;

    always_comb begin
        sh_d  = load_i ? bytes_i : hs ? (sh_q >> 8) : sh_q;
        len_d = load_i ? len_i : hs ? len_q - 3'd1 : len_q;
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            sh_q  <= '0;
            len_q <= '0;
        end else begin
            sh_q  <= sh_d;
            len_q <= len_d;
        end
    end

endmodule

// File: rtl/uart_mem_server.sv
// uart_mem_server: parses READ/WRITE frames from a UART byte stream, runs them on a
// word-wide memory port and answers with ACK (plus read data) or RESEND frames.
module uart_mem_server
    import uart_mem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_e                     state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic [7:0]                 xor_q, xor_d;
    logic [TW-1:0]              tmr_q, tmr_d;
    logic                       we_q, we_d;
    logic                       req_q, req_d;
    logic                       ferr_q, ferr_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic [DATA_W-1:0]          wdata_q, wdata_d;
    logic [3:0]                 frame_len;
    logic                       rej;
    logic                       ld;
    logic [2:0]                 ld_len;
    logic [RDRESP_LEN-1:0][7:0] ld_bytes;
    logic                       tx_busy;

    assign frame_len = we_q ? 4'(WRITE_LEN) : 4'(READ_LEN);
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign frame_err = ferr_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        xor_d    = xor_q;
        tmr_d    = tmr_q;
        we_d     = we_q;
        req_d    = req_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ferr_d   = 1'b0;
        rej      = 1'b0;
        ld       = 1'b0;
        ld_len   = 3'd0;
        ld_bytes = '0;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_READ || rx_data == CMD_WRITE) begin
                        state_d = ST_RECV;
                        cnt_d   = 4'd1;
                        xor_d   = rx_data;
                        tmr_d   = '0;
                        we_d    = rx_data == CMD_WRITE;
                    end else begin
                        rej = 1'b1;
                    end
                end
            end
            ST_RECV: begin
                // a byte arriving in the expiry cycle wins and reloads the timer
                if (rx_valid) begin
                    tmr_d = '0;
                    cnt_d = cnt_q + 4'd1;
                    xor_d = xor_q ^ rx_data;
                    if (cnt_q == frame_len - 4'd1) begin
                        if (xor_q == rx_data) begin
                            state_d = ST_MEM;
                            req_d   = 1'b1;
                        end else begin
                            rej = 1'b1;
                        end
                    end else if (cnt_q < 4'd3) begin
                        addr_d = {addr_q[ADDR_W-9:0], rx_data};
                    end else begin
                        wdata_d = {wdata_q[DATA_W-9:0], rx_data};
                    end
                end else if (tmr_q == TW'(TIMEOUT_CYC - 1)) begin
                    rej = 1'b1;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    req_d    = 1'b0;
                    state_d  = ST_SEND;
                    ld       = 1'b1;
                    ld_len   = we_q ? 3'd1 : 3'(RDRESP_LEN);
                    ld_bytes = {CMD_ACK ^ xor_word(mem_rdata[31:0]), mem_rdata[7:0], mem_rdata[15:8],
                                mem_rdata[23:16], mem_rdata[31:24], 8'(CMD_ACK)};
                end
            end
            ST_REJECT: state_d = ST_SEND;
            ST_SEND:   state_d = tx_busy ? ST_SEND : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (rej) begin
            state_d     = ST_REJECT;
            ferr_d      = 1'b1;
            ld          = 1'b1;
            ld_len      = 3'd1;
            ld_bytes[0] = CMD_RESEND;
        end
        // half-duplex: bytes arriving while busy are dropped and flagged
        if (rx_valid && (state_q == ST_MEM || state_q == ST_REJECT || state_q == ST_SEND))
            ferr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            xor_q   <= '0;
            tmr_q   <= '0;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
            ferr_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xor_q   <= xor_d;
            tmr_q   <= tmr_d;
            we_q    <= we_d;
            req_q   <= req_d;
            ferr_q  <= ferr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    uart_mem_txq u_txq (
        .clk        (clk),
        .res_n      (res_n),
        .load_i     (ld),
        .bytes_i    (ld_bytes),
        .len_i      (ld_len),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .busy_o     (tx_busy)
    );

endmodule
